// File: rtl/calculadora_ctrl.sv
// calculadora_ctrl: sequencing controller for the 8-bit combinational calculator.
// Accepts commands on a valid/ready channel, keeps an accumulator, drives the
// calculator's codigo/A/B ports and returns one result per command.
// Optional build macro CALC_CTRL_SAT_EN: saturate the accumulator on overflow
// (ADD/MUL to all-ones, SUB to zero) instead of modulo wrap.
module calculadora_ctrl #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [LARGURA-1:0] cmd_dado,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LARGURA-1:0] res_dado,
  output logic               res_ovf,
  output logic               res_erro,
  output logic [2:0]         alu_codigo,
  output logic [LARGURA-1:0] alu_A,
  output logic [LARGURA-1:0] alu_B,
  input  logic [LARGURA-1:0] alu_saida
);

  // Command opcodes
  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_READ = 3'b101;

  // Calculator function codes
  localparam logic [2:0] COD_ZERO = 3'b000;
  localparam logic [2:0] COD_B    = 3'b010;
  localparam logic [2:0] COD_ADD  = 3'b011;
  localparam logic [2:0] COD_SUB  = 3'b100;

`ifdef CALC_CTRL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO,
    EXEC,
    MUL,
    RESP
  } estado_t;

  estado_t              estado;
  estado_t              prox_estado;

  logic [2:0]           op_q;
  logic [LARGURA-1:0]   dado_q;
  logic [LARGURA-1:0]   acc;
  logic [LARGURA-1:0]   parcial;
  logic [LARGURA-1:0]   cont;
  logic                 mul_ovf;
  logic                 ovf_q;
  logic                 erro_q;

  logic                 aceita;
  logic                 mul_zero;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic                 mul_wrap;
  logic                 mul_ovf_tot;
  logic                 mul_fim;

  // The result value is the accumulator itself: it only changes while busy,
  // so it is naturally stable for the whole RESP state.
  assign res_dado = acc;
  assign res_ovf  = ovf_q;
  assign res_erro = erro_q;

  // Handshake decode and overflow detection from the calculator output
  always_comb begin
    aceita      = 1'b0;
    mul_zero    = 1'b0;
    add_ovf     = 1'b0;
    sub_ovf     = 1'b0;
    mul_wrap    = 1'b0;
    mul_ovf_tot = 1'b0;
    mul_fim     = 1'b0;
    aceita      = (estado == OCIOSO) && cmd_valid;
    mul_zero    = (cmd_op == OP_MUL) && (cmd_dado == '0);
    add_ovf     = alu_saida < acc;
    sub_ovf     = dado_q > acc;
    // A partial sum wraps exactly when the new partial is below the old one.
    mul_wrap    = alu_saida < parcial;
    mul_ovf_tot = mul_ovf | mul_wrap;
    mul_fim     = cont == LARGURA'(1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Next-state and state-decoded outputs (no input-to-output paths)
  always_comb begin
    prox_estado = estado;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    alu_codigo  = COD_ZERO;
    alu_A       = '0;
    alu_B       = '0;
    case (estado)
      OCIOSO: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_MUL) begin
            prox_estado = (cmd_dado == '0) ? RESP : MUL;
          end else begin
            prox_estado = EXEC;
          end
        end
      end
      EXEC: begin
        case (op_q)
          OP_LOAD: begin
            alu_codigo = COD_B;
            alu_B      = dado_q;
          end
          OP_ADD: begin
            alu_codigo = COD_ADD;
            alu_A      = acc;
            alu_B      = dado_q;
          end
          OP_SUB: begin
            alu_codigo = COD_SUB;
            alu_A      = acc;
            alu_B      = dado_q;
          end
          default: alu_codigo = COD_ZERO;
        endcase
        prox_estado = RESP;
      end
      MUL: begin
        alu_codigo = COD_ADD;
        alu_A      = parcial;
        alu_B      = acc;
        if (mul_fim) begin
          prox_estado = RESP;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          prox_estado = OCIOSO;
        end
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // Command latch, accumulator, multiply iteration and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      dado_q  <= '0;
      acc     <= '0;
      parcial <= '0;
      cont    <= '0;
      mul_ovf <= 1'b0;
      ovf_q   <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            op_q    <= cmd_op;
            dado_q  <= cmd_dado;
            parcial <= '0;
            cont    <= cmd_dado;
            mul_ovf <= 1'b0;
            ovf_q   <= 1'b0;
            erro_q  <= 1'b0;
            if (mul_zero) begin
              acc <= '0;
            end
          end
        end
        EXEC: begin
          case (op_q)
            OP_CLR: acc <= alu_saida;
            OP_LOAD: acc <= alu_saida;
            OP_ADD: begin
              acc   <= (SAT && add_ovf) ? '1 : alu_saida;
              ovf_q <= add_ovf;
            end
            OP_SUB: begin
              acc   <= (SAT && sub_ovf) ? '0 : alu_saida;
              ovf_q <= sub_ovf;
            end
            OP_READ: acc <= acc;
            default: erro_q <= 1'b1;
          endcase
        end
        MUL: begin
          parcial <= alu_saida;
          cont    <= cont - LARGURA'(1);
          mul_ovf <= mul_ovf_tot;
          if (mul_fim) begin
            acc   <= (SAT && mul_ovf_tot) ? '1 : alu_saida;
            ovf_q <= mul_ovf_tot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calculadora_ctrl.sv
// Self-checking bench for calculadora_ctrl with a behavioural calculator model.
module tb_calculadora_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_dado;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dado;
  logic       res_ovf;
  logic       res_erro;
  logic [2:0] alu_codigo;
  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic [7:0] alu_saida;

  int n_cmp = 0;
  int n_bad = 0;

  calculadora_ctrl #(.LARGURA(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dado   (cmd_dado),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_dado   (res_dado),
    .res_ovf    (res_ovf),
    .res_erro   (res_erro),
    .alu_codigo (alu_codigo),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_saida  (alu_saida)
  );

  always #5 clk = ~clk;

  // Combinational calculator being sequenced
  always_comb begin
    alu_saida = 8'h00;
    case (alu_codigo)
      3'b001:  alu_saida = alu_A;
      3'b010:  alu_saida = alu_B;
      3'b011:  alu_saida = alu_A + alu_B;
      3'b100:  alu_saida = alu_A - alu_B;
      default: alu_saida = 8'h00;
    endcase
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
    end
  endtask

  // Issue one command, wait for its result, take it; reports latency and
  // the number of cycles the calculator was driven with the add code.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                        output logic [7:0] r, output logic o, output logic e,
                        output int lat, output int n011);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    cmd_op    = op;
    cmd_dado  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat  = 1;
    n011 = 0;
    while (!res_valid && lat < 1000) begin
      if (alu_codigo == 3'b011) n011++;
      @(posedge clk); #1;
      lat++;
    end
    r = res_dado;
    o = res_ovf;
    e = res_erro;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] dado;
    logic [7:0] exp_res;
    logic       exp_ovf;
    logic       exp_erro;
    int         exp_lat;
    int         exp_add;
  } vec_t;

`ifdef CALC_CTRL_SAT_EN
  localparam logic [7:0] ADD_OVF_R = 8'hFF;
  localparam logic [7:0] SUB_OVF_R = 8'h00;
  localparam logic [7:0] MUL9_R    = 8'hFF;
  localparam logic [7:0] MUL16_R   = 8'hFF;
`else
  localparam logic [7:0] ADD_OVF_R = 8'h10;
  localparam logic [7:0] SUB_OVF_R = 8'hFE;
  localparam logic [7:0] MUL9_R    = 8'h20;
  localparam logic [7:0] MUL16_R   = 8'h00;
`endif

  vec_t       v [20];
  logic [7:0] r;
  logic       o;
  logic       e;
  int         lat;
  int         n011;

  initial begin
    // op, dado, result, ovf, erro, latency, add-code cycles
    v[0]  = '{3'b001, 8'h12, 8'h12, 1'b0, 1'b0, 2, 0};
    v[1]  = '{3'b010, 8'h05, 8'h17, 1'b0, 1'b0, 2, 1};
    v[2]  = '{3'b101, 8'h00, 8'h17, 1'b0, 1'b0, 2, 0};
    v[3]  = '{3'b001, 8'hF0, 8'hF0, 1'b0, 1'b0, 2, 0};
    v[4]  = '{3'b010, 8'h20, ADD_OVF_R, 1'b1, 1'b0, 2, 1};
    v[5]  = '{3'b001, 8'h03, 8'h03, 1'b0, 1'b0, 2, 0};
    v[6]  = '{3'b011, 8'h05, SUB_OVF_R, 1'b1, 1'b0, 2, 0};
    v[7]  = '{3'b000, 8'h77, 8'h00, 1'b0, 1'b0, 2, 0};
    v[8]  = '{3'b001, 8'h07, 8'h07, 1'b0, 1'b0, 2, 0};
    v[9]  = '{3'b100, 8'h06, 8'h2A, 1'b0, 1'b0, 7, 6};
    v[10] = '{3'b100, 8'h00, 8'h00, 1'b0, 1'b0, 1, 0};
    v[11] = '{3'b001, 8'h20, 8'h20, 1'b0, 1'b0, 2, 0};
    v[12] = '{3'b100, 8'h09, MUL9_R, 1'b1, 1'b0, 10, 9};
    v[13] = '{3'b001, 8'h5A, 8'h5A, 1'b0, 1'b0, 2, 0};
    v[14] = '{3'b111, 8'h33, 8'h5A, 1'b0, 1'b1, 2, 0};
    v[15] = '{3'b110, 8'h01, 8'h5A, 1'b0, 1'b1, 2, 0};
    v[16] = '{3'b011, 8'h5A, 8'h00, 1'b0, 1'b0, 2, 0};
    v[17] = '{3'b010, 8'hFF, 8'hFF, 1'b0, 1'b0, 2, 1};
    v[18] = '{3'b001, 8'h10, 8'h10, 1'b0, 1'b0, 2, 0};
    v[19] = '{3'b100, 8'h10, MUL16_R, 1'b1, 1'b0, 17, 16};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_dado  = 8'h00;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_dado", 32'(res_dado), 32'h00);
    chk("rst res_ovf", 32'(res_ovf), 32'd0);
    chk("rst res_erro", 32'(res_erro), 32'd0);
    chk("rst alu_codigo", 32'(alu_codigo), 32'd0);
    chk("rst alu_A", 32'(alu_A), 32'd0);
    chk("rst alu_B", 32'(alu_B), 32'd0);

    for (int unsigned i = 0; i < 20; i++) begin
      do_cmd(v[i].op, v[i].dado, r, o, e, lat, n011);
      chk($sformatf("vec%0d res", i), 32'(r), 32'(v[i].exp_res));
      chk($sformatf("vec%0d ovf", i), 32'(o), 32'(v[i].exp_ovf));
      chk($sformatf("vec%0d erro", i), 32'(e), 32'(v[i].exp_erro));
      chk($sformatf("vec%0d lat", i), 32'(lat), 32'(v[i].exp_lat));
      chk($sformatf("vec%0d addcyc", i), 32'(n011), 32'(v[i].exp_add));
    end

    // Back-pressure: result held 5 cycles while another command waits
    do_cmd(3'b001, 8'h44, r, o, e, lat, n011);
    chk("bp load", 32'(r), 32'h44);
    cmd_op    = 3'b001;
    cmd_dado  = 8'h80;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp res_valid", 32'(res_valid), 32'd1);
    cmd_op    = 3'b010;
    cmd_dado  = 8'h01;
    cmd_valid = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d res_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("bp hold%0d res_dado", k), 32'(res_dado), 32'h80);
      chk($sformatf("bp hold%0d cmd_ready", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp hold%0d alu_codigo", k), 32'(alu_codigo), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp ready after take", 32'(cmd_ready), 32'd1);
    chk("bp valid after take", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp pending accepted", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp pending lat", 32'(lat), 32'd2);
    chk("bp pending res", 32'(res_dado), 32'h81);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset in the middle of a long multiply aborts it
    do_cmd(3'b001, 8'h03, r, o, e, lat, n011);
    chk("abort load", 32'(r), 32'h03);
    cmd_op    = 3'b100;
    cmd_dado  = 8'hFF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort busy", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #3;
    chk("abort acc", 32'(res_dado), 32'h00);
    chk("abort alu_codigo", 32'(alu_codigo), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
    n011 = 0;
    for (int unsigned k = 0; k < 300; k++) begin
      if (res_valid) n011++;
      @(posedge clk); #1;
    end
    chk("abort no result", 32'(n011), 32'd0);
    do_cmd(3'b101, 8'h00, r, o, e, lat, n011);
    chk("abort read acc", 32'(r), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
